npc_lsu: RTL

//  Multicycle load/store unit directly downstream of the execute stage. Takes the ALU result as the

---
 rtl/npc_lsu_pkg.sv | 22 ++
 rtl/lsu_load_align.sv | 22 ++
 rtl/npc_lsu.sv | 113 +++++++++++
 3 files changed

// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: shared state encoding, access-size decode and mcause codes for the load/store unit
package npc_lsu_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
      return (f3[1:0] == SZ_H && a[0]) || (f3[1:0] == SZ_W && a != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half from a raw read word and sign- or zero-extends it
module lsu_load_align
   import npc_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      a,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   logic        sx;
   assign b  = rdata[{a, 3'b000} +: 8];
   assign h  = rdata[{a[1], 4'b0000} +: 16];
   assign sx = ~funct3[2];
   // unsigned variants share the size bits and only drop the sign fill
   always_comb
      data = funct3[1:0] == SZ_B ? {{(XLEN-8){sx & b[7]}}, b} :
             funct3[1:0] == SZ_H ? {{(XLEN-16){sx & h[15]}}, h} : rdata;
endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: multicycle load/store unit between execute and writeback with misalign/timeout faults
module npc_lsu
   import npc_lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_addr,
   input  logic [XLEN-1:0] in_wdata,
   input  logic            in_is_load,
   input  logic            in_is_store,
   input  logic [2:0]      in_funct3,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   output logic            mem_req_wen,
   output logic [XLEN-1:0] mem_req_wdata,
   output logic [3:0]      mem_req_wmask,
   input  logic            mem_resp_valid,
   input  logic [XLEN-1:0] mem_resp_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            out_fault,
   output logic [3:0]      out_cause
);
   logic [1:0]      state;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic            ld_q;
   logic            st_q;
   logic [2:0]      f3_q;
   logic [7:0]      cnt;
   logic [XLEN-1:0] load_data;
   logic [3:0]      mask;

   lsu_load_align #(.XLEN(XLEN)) u_align (
      .rdata  (mem_resp_rdata),
      .a      (addr_q[1:0]),
      .funct3 (f3_q),
      .data   (load_data)
   );

   assign in_ready      = state == S_IDLE;
   assign out_valid     = state == S_DONE;
   assign mem_req_valid = state == S_REQ;
   assign mem_req_addr  = mem_req_valid ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign mem_req_wen   = mem_req_valid & st_q;
   assign mask          = f3_q[1:0] == SZ_B ? 4'b0001 : f3_q[1:0] == SZ_H ? 4'b0011 : 4'b1111;
   assign mem_req_wmask = mem_req_valid ? mask << addr_q[1:0] : 4'b0000;
   assign mem_req_wdata = !mem_req_wen ? '0 :
                          f3_q[1:0] == SZ_B ? {(XLEN/8){wdata_q[7:0]}} :
                          f3_q[1:0] == SZ_H ? {(XLEN/16){wdata_q[15:0]}} : wdata_q;

   // single-outstanding access FSM; results are registered on entry to DONE and held until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ld_q      <= 1'b0;
         st_q      <= 1'b0;
         f3_q      <= '0;
         out_data  <= '0;
         out_fault <= 1'b0;
         out_cause <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               addr_q    <= in_addr;
               wdata_q   <= in_wdata;
               ld_q      <= in_is_load;
               st_q      <= in_is_store & ~in_is_load;
               f3_q      <= in_funct3;
               out_data  <= '0;
               out_fault <= 1'b0;
               out_cause <= '0;
               if (!in_is_load && !in_is_store) begin
                  state    <= S_DONE;
                  out_data <= in_addr;
               end else if (misaligned(in_funct3, in_addr[1:0])) begin
                  state     <= S_DONE;
                  out_fault <= 1'b1;
                  out_cause <= in_is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
               end else begin
                  state <= S_REQ;
               end
            end
            S_REQ: if (mem_req_ready) begin
               state <= S_WAIT;
               cnt   <= '0;
            end
            S_WAIT: begin
               cnt <= cnt + 8'd1;
               if (mem_resp_valid) begin
                  state    <= S_DONE;
                  out_data <= ld_q ? load_data : '0;
               end else if (cnt == 8'(TIMEOUT)) begin
                  state     <= S_DONE;
                  out_fault <= 1'b1;
                  out_cause <= ld_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
               end
            end
            default: if (out_ready) state <= S_IDLE;
         endcase
      end
   end
endmodule
